latch_input_conditioner: RTL and testbench

- Upstream stage for the gated D latch. Takes the raw board switch/button levels for D and G and produces clean, debounced D and G levels that drive the latch inputs directly.
- Each channel has a 2-FF synchronizer, a stability counter and a one-cycle edge-pulse generator.
- The two channels (D, G) are identical and fully independent. All logic runs in a single clock domain.

---
 rtl/latch_input_conditioner.sv | 128 ++++++++++++
 tb/tb_latch_input_conditioner.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_input_conditioner.sv
// Synchronizes and debounces the raw D/G switch levels for the gated
// D latch, with registered one-cycle rise/fall pulses per channel.
module debounce_stage #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl,
  output logic rise,
  output logic fall
);

  typedef enum logic {STABLE, COUNTING} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic             s1, s2;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             lvl_n, rise_n, fall_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= STABLE;
      cnt   <= '0;
      lvl   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      state <= state_n;
      cnt   <= cnt_n;
      lvl   <= lvl_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  // A single differing sample suffices when DEBOUNCE_CYCLES is 1.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lvl_n   = lvl;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    unique case (state)
      STABLE: begin
        if (s2 != lvl) begin
          if (DEBOUNCE_CYCLES == 1) begin
            lvl_n  = s2;
            rise_n = s2;
            fall_n = ~s2;
          end else begin
            state_n = COUNTING;
            cnt_n   = ONE;
          end
        end
      end
      COUNTING: begin
        if (s2 == lvl) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n = STABLE;
          cnt_n   = '0;
          lvl_n   = s2;
          rise_n  = s2;
          fall_n  = ~s2;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = STABLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

module latch_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 20
) (
  input  logic Clk,
  input  logic reset,
  input  logic d_raw,
  input  logic g_raw,
  output logic D,
  output logic G,
  output logic d_rise,
  output logic d_fall,
  output logic g_rise,
  output logic g_fall
);

  debounce_stage #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_d (
    .clk (Clk),
    .rst (reset),
    .raw (d_raw),
    .lvl (D),
    .rise(d_rise),
    .fall(d_fall)
  );

  debounce_stage #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_g (
    .clk (Clk),
    .rst (reset),
    .raw (g_raw),
    .lvl (G),
    .rise(g_rise),
    .fall(g_fall)
  );

endmodule

// File: tb/tb_latch_input_conditioner.sv
// Bench for latch_input_conditioner: N=4 and N=1 builds side by side,
// checked against a run-length reference model and fixed vectors.
module tb_latch_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d_raw = 1'b0;
  logic g_raw = 1'b0;

  logic D4, G4, dr4, df4, gr4, gf4;
  logic D1, G1, dr1, df1, gr1, gf1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  latch_input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) u_n4 (
    .Clk(clk), .reset(rst), .d_raw(d_raw), .g_raw(g_raw),
    .D(D4), .G(G4), .d_rise(dr4), .d_fall(df4),
    .g_rise(gr4), .g_fall(gf4)
  );

  latch_input_conditioner #(.DEBOUNCE_CYCLES(1), .CNT_W(4)) u_n1 (
    .Clk(clk), .reset(rst), .d_raw(d_raw), .g_raw(g_raw),
    .D(D1), .G(G1), .d_rise(dr1), .d_fall(df1),
    .g_rise(gr1), .g_fall(gf1)
  );

  // Reference: raw is seen two edges late; the level flips once it has
  // differed from the output on nd[i] consecutive edges.
  int nd[2] = '{4, 1};
  bit rh1[2], rh2[2];
  bit m_out[2][2], m_rise[2][2], m_fall[2][2];
  int run[2][2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      rh1[c] = 0;
      rh2[c] = 0;
      for (int i = 0; i < 2; i++) begin
        m_out[i][c]  = 0;
        m_rise[i][c] = 0;
        m_fall[i][c] = 0;
        run[i][c]    = 0;
      end
    end
  endtask

  task automatic model_step();
    bit raw[2];
    bit samp;
    raw[0] = d_raw;
    raw[1] = g_raw;
    for (int c = 0; c < 2; c++) begin
      samp   = rh2[c];
      rh2[c] = rh1[c];
      rh1[c] = raw[c];
      for (int i = 0; i < 2; i++) begin
        m_rise[i][c] = 0;
        m_fall[i][c] = 0;
        if (samp == m_out[i][c]) begin
          run[i][c] = 0;
        end else begin
          run[i][c]++;
          if (run[i][c] == nd[i]) begin
            m_out[i][c]  = samp;
            m_rise[i][c] = samp;
            m_fall[i][c] = !samp;
            run[i][c]    = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic check_all();
    bit lv[2][2], ri[2][2], fa[2][2];
    lv[0][0] = D4; lv[0][1] = G4; lv[1][0] = D1; lv[1][1] = G1;
    ri[0][0] = dr4; ri[0][1] = gr4; ri[1][0] = dr1; ri[1][1] = gr1;
    fa[0][0] = df4; fa[0][1] = gf4; fa[1][0] = df1; fa[1][1] = gf1;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("model_lvl n%0d c%0d", nd[i], c),
            int'(lv[i][c]), int'(m_out[i][c]));
        chk($sformatf("model_rise n%0d c%0d", nd[i], c),
            int'(ri[i][c]), int'(m_rise[i][c]));
        chk($sformatf("model_fall n%0d c%0d", nd[i], c),
            int'(fa[i][c]), int'(m_fall[i][c]));
      end
  endtask

  // Check outputs after the coming edge, then apply the next inputs.
  task automatic tick(input bit d, input bit g);
    @(posedge clk);
    model_step();
    #1;
    check_all();
    d_raw = d;
    g_raw = g;
  endtask

  task automatic do_reset();
    d_raw = 0;
    g_raw = 0;
    rst   = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  typedef struct {
    bit d;
    bit g;
    bit e_d4;
    bit e_r4;
    bit e_d1;
    bit e_r1;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf, nr;
    bit dv, gv;

    tbl[0] = '{1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 0, 1, 1};
    tbl[3] = '{1, 0, 0, 0, 1, 0};
    tbl[4] = '{1, 0, 0, 0, 1, 0};
    tbl[5] = '{1, 0, 1, 1, 1, 0};
    tbl[6] = '{1, 0, 1, 0, 1, 0};
    tbl[7] = '{1, 0, 1, 0, 1, 0};

    model_reset();
    #2;
    chk("reset_D4", int'(D4), 0);
    chk("reset_G4", int'(G4), 0);
    chk("reset_pulses", int'({dr4, df4, gr4, gf4}), 0);
    do_reset();

    tick(1, 0);
    for (int r = 0; r < 8; r++) begin
      tick(tbl[r].d, tbl[r].g);
      chk($sformatf("step_D4 e%0d", r + 1), int'(D4), int'(tbl[r].e_d4));
      chk($sformatf("step_rise4 e%0d", r + 1), int'(dr4), int'(tbl[r].e_r4));
      chk($sformatf("step_fall4 e%0d", r + 1), int'(df4), 0);
      chk($sformatf("step_D1 e%0d", r + 1), int'(D1), int'(tbl[r].e_d1));
      chk($sformatf("step_rise1 e%0d", r + 1), int'(dr1), int'(tbl[r].e_r1));
    end

    for (int len = 1; len <= 3; len += 2) begin
      nf = 0;
      nr = 0;
      for (int k = 0; k < len + 10; k++) begin
        tick(k < len ? 1'b0 : 1'b1, 0);
        chk($sformatf("glitch%0d_D4", len), int'(D4), 1);
        chk($sformatf("glitch%0d_fall4", len), int'(df4), 0);
        nf += int'(df1);
        nr += int'(dr1);
      end
      chk($sformatf("glitch%0d_falls1", len), nf, 1);
      chk($sformatf("glitch%0d_rises1", len), nr, 1);
      chk($sformatf("glitch%0d_D1", len), int'(D1), 1);
    end

    tick(0, 0);
    for (int k = 1; k <= 14; k++) begin
      tick(k < 4 ? 1'b0 : 1'b1, 0);
      chk($sformatf("low4_D4 e%0d", k), int'(D4), (k >= 6 && k < 10) ? 0 : 1);
      chk($sformatf("low4_fall4 e%0d", k), int'(df4), k == 6 ? 1 : 0);
      chk($sformatf("low4_rise4 e%0d", k), int'(dr4), k == 10 ? 1 : 0);
    end

    do_reset();
    for (int k = 0; k <= 14; k++) begin
      tick(0, k <= 4 ? (k % 2 == 0) : 1'b1);
      chk($sformatf("bounce_G4 e%0d", k), int'(G4), k >= 10 ? 1 : 0);
      chk($sformatf("bounce_rise4 e%0d", k), int'(gr4), k == 10 ? 1 : 0);
      chk($sformatf("bounce_fall4 e%0d", k), int'(gf4), 0);
    end

    do_reset();
    tick(1, 0);
    for (int k = 1; k <= 5; k++) tick(1, 0);
    rst = 1;
    model_reset();
    #1;
    chk("midrst_D4", int'(D4), 0);
    chk("midrst_D1", int'(D1), 0);
    chk("midrst_pulses", int'({dr4, df4, dr1, df1}), 0);
    check_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    for (int k = 1; k <= 8; k++) begin
      tick(1, 0);
      chk($sformatf("midrst_rel_D4 e%0d", k), int'(D4), k >= 6 ? 1 : 0);
      chk($sformatf("midrst_rel_rise4 e%0d", k), int'(dr4), k == 6 ? 1 : 0);
    end

    do_reset();
    tick(1, 1);
    for (int k = 1; k <= 8; k++) begin
      tick(1, 1);
      chk($sformatf("simul_DG4 e%0d", k), int'({D4, G4}), k >= 6 ? 3 : 0);
      chk($sformatf("simul_rises4 e%0d", k), int'({dr4, gr4}), k == 6 ? 3 : 0);
    end
    tick(0, 1);
    for (int k = 1; k <= 8; k++) begin
      tick(0, 1);
      chk($sformatf("donly_G4 e%0d", k), int'(G4), 1);
      chk($sformatf("donly_gpulse4 e%0d", k), int'({gr4, gf4}), 0);
      chk($sformatf("donly_D4 e%0d", k), int'(D4), k >= 6 ? 0 : 1);
    end

    dv = 0;
    gv = 0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) dv = ~dv;
      if ($urandom_range(0, 3) == 0) gv = ~gv;
      tick(dv, gv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
